// File: rtl/whack_button_frontend.sv
// Button input conditioner: synchronise, debounce, edge-detect and queue presses as whack events.
// Optional WHACK_MULTI_REJECT_EN: a cycle with more than one rising edge queues nothing.
module whack_button_frontend #(
    parameter int N_BTN           = 8,
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int CNT_W           = 13,
    localparam int IDX_W          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             hit_ready,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_idx,
    output logic [N_BTN-1:0] btn_level,
    output logic             multi_press,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] btn_level_reg;
    logic [N_BTN-1:0] level_next;
    logic [N_BTN-1:0] rise_next;
    logic [N_BTN-1:0] rise_reg;
    logic             multi_press_reg;
    logic             multi_next;
    logic [N_BTN-1:0] pending_reg;
    logic [N_BTN-1:0] pending_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic [N_BTN-1:0] accept_mask;
    logic [N_BTN-1:0] set_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Each button owns its counter; the level only moves after a full run of stable samples.
    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] cnt_reg;
            logic             differs;
            logic             expired;

            assign differs        = sync2_reg[gi] ^ btn_level_reg[gi];
            assign expired        = differs && (cnt_reg == CNT_MAX);
            assign level_next[gi] = btn_level_reg[gi] ^ expired;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!differs || expired) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign rise_next  = level_next & ~btn_level_reg;
    // More than one bit set <=> clearing the lowest set bit leaves something behind.
    assign multi_next = |(rise_next & (rise_next - 1'b1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_level_reg   <= '0;
            rise_reg        <= '0;
            multi_press_reg <= 1'b0;
        end else begin
            btn_level_reg   <= level_next;
            rise_reg        <= rise_next;
            multi_press_reg <= multi_next;
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_valid = (|pending_reg) && ena;

    always_comb begin
        accept_mask = '0;
        if (hit_valid && hit_ready) begin
            accept_mask[hit_idx] = 1'b1;
        end
    end

`ifdef WHACK_MULTI_REJECT_EN
    assign set_mask = multi_press_reg ? '0 : rise_reg;
`else
    assign set_mask = rise_reg;
`endif

    // A press landing on a bit accepted this same cycle is simply re-queued, not an overflow.
    always_comb begin
        pending_next  = pending_reg;
        overflow_next = overflow_reg;
        if (!ena) begin
            pending_next = '0;
        end else begin
            overflow_next = overflow_reg | (|(set_mask & pending_reg & ~accept_mask));
            pending_next  = (pending_reg & ~accept_mask) | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
        end
    end

    assign btn_level   = btn_level_reg;
    assign multi_press = multi_press_reg;
    assign overflow    = overflow_reg;

endmodule
